// File: rtl/s2mem_burst_writer.sv
`default_nettype none
// ============================================================================
// Module     : s2mem_burst_writer
// Description: Buffers words from the AXI4-Stream reader stage in a
//              first-word-fall-through FIFO and writes them to memory as
//              address/data bursts, starting at base_addr, for total_words
//              words. Reports busy and a one-cycle done pulse.
// Revision   : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   ACLK            in   clock, rising edge
//   ARESET          in   synchronous active-high reset
//   start           in   one-cycle pulse, begins a transfer when idle
//   base_addr       in   first byte address, sampled on start
//   total_words     in   number of words, sampled on start
//   busy            out  transfer in progress
//   done            out  one-cycle pulse at end of transfer
//   ready           out  upstream word accepted this cycle if data_valid
//   data_valid      in   upstream word present
//   data            in   upstream word
//   MEM_REQ_VALID   out  burst request valid
//   MEM_REQ_READY   in   burst request accepted
//   MEM_REQ_ADDR    out  burst start byte address
//   MEM_REQ_LEN     out  beats-1 of the burst
//   MEM_WDATA_VALID out  write beat valid
//   MEM_WDATA_READY in   write beat accepted
//   MEM_WDATA       out  write beat data
//   MEM_WDATA_LAST  out  final beat of the burst
// ============================================================================
module s2mem_burst_writer #(
  parameter int C_DATA_WIDTH      = 32,
  parameter int C_ADDR_WIDTH      = 32,
  parameter int C_BURST_LEN       = 16,
  parameter int C_FIFO_DEPTH_LOG2 = 5
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    start,
  input  logic [C_ADDR_WIDTH-1:0] base_addr,
  input  logic [31:0]             total_words,
  output logic                    busy,
  output logic                    done,
  output logic                    ready,
  input  logic                    data_valid,
  input  logic [C_DATA_WIDTH-1:0] data,
  output logic                    MEM_REQ_VALID,
  input  logic                    MEM_REQ_READY,
  output logic [C_ADDR_WIDTH-1:0] MEM_REQ_ADDR,
  output logic [7:0]              MEM_REQ_LEN,
  output logic                    MEM_WDATA_VALID,
  input  logic                    MEM_WDATA_READY,
  output logic [C_DATA_WIDTH-1:0] MEM_WDATA,
  output logic                    MEM_WDATA_LAST
);

  localparam int c_aw    = C_FIFO_DEPTH_LOG2;
  localparam int c_depth = 1 << C_FIFO_DEPTH_LOG2;
  localparam int c_bytes = C_DATA_WIDTH / 8;

  localparam logic [c_aw:0]           c_full_cnt   = c_depth[c_aw:0];
  localparam logic [c_aw:0]           c_cnt_one    = {{c_aw{1'b0}}, 1'b1};
  localparam logic [c_aw-1:0]         c_ptr_one    = {{(c_aw-1){1'b0}}, 1'b1};
  localparam logic [C_ADDR_WIDTH-1:0] c_word_bytes = C_ADDR_WIDTH'(c_bytes);
  localparam logic [8:0]              c_burst      = 9'(C_BURST_LEN);

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_fill = 3'd1;
  localparam logic [2:0] c_st_req  = 3'd2;
  localparam logic [2:0] c_st_data = 3'd3;
  localparam logic [2:0] c_st_done = 3'd4;

  logic [2:0]              r_state;
  logic [2:0]              w_state_nxt;
  logic [C_ADDR_WIDTH-1:0] r_addr;
  logic [31:0]             r_remaining;
  logic [31:0]             r_total;
  logic [31:0]             r_accepted;
  logic [8:0]              r_beat;

  logic [C_DATA_WIDTH-1:0] r_mem [c_depth];
  logic [c_aw-1:0]         r_wr_ptr;
  logic [c_aw-1:0]         r_rd_ptr;
  logic [c_aw:0]           r_count;

  logic [8:0]  w_blen;
  logic [8:0]  w_blen_m1;
  logic [31:0] w_rem_after;
  logic        w_busy;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_last_beat;
  logic        w_burst_done;

  // Remaining is only updated at the end of a burst, so the burst length
  // stays stable from FILL through the last beat of DATA.
  assign w_blen       = (r_remaining >= 32'(C_BURST_LEN)) ? c_burst : r_remaining[8:0];
  assign w_blen_m1    = w_blen - 9'd1;
  assign w_rem_after  = r_remaining - 32'(w_blen);
  assign w_busy       = (r_state == c_st_fill) || (r_state == c_st_req) || (r_state == c_st_data);
  assign w_fifo_full  = (r_count == c_full_cnt);
  assign w_fifo_empty = (r_count == '0);
  assign w_push       = ready & data_valid;
  assign w_pop        = (r_state == c_st_data) & ~w_fifo_empty & MEM_WDATA_READY;
  assign w_last_beat  = (r_beat == w_blen_m1);
  assign w_burst_done = w_pop & w_last_beat;

  // State register
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (start) begin
          w_state_nxt = (total_words == 32'd0) ? c_st_done : c_st_fill;
        end
      end
      c_st_fill: begin
        if (32'(r_count) >= 32'(w_blen)) begin
          w_state_nxt = c_st_req;
        end
      end
      c_st_req: begin
        if (MEM_REQ_READY) begin
          w_state_nxt = c_st_data;
        end
      end
      c_st_data: begin
        if (w_burst_done) begin
          w_state_nxt = (w_rem_after == 32'd0) ? c_st_done : c_st_fill;
        end
      end
      c_st_done: begin
        w_state_nxt = c_st_idle;
      end
      default: begin
        w_state_nxt = c_st_idle;
      end
    endcase
  end

  // Output logic; payloads are forced to zero outside their valid states so
  // the memory-side bus is quiet while idle and right after reset.
  always_comb begin
    busy            = w_busy;
    done            = (r_state == c_st_done);
    ready           = w_busy & ~w_fifo_full & (r_accepted < r_total);
    MEM_REQ_VALID   = 1'b0;
    MEM_REQ_ADDR    = '0;
    MEM_REQ_LEN     = 8'd0;
    MEM_WDATA_VALID = 1'b0;
    MEM_WDATA       = '0;
    MEM_WDATA_LAST  = 1'b0;
    if (r_state == c_st_req) begin
      MEM_REQ_VALID = 1'b1;
      MEM_REQ_ADDR  = r_addr;
      MEM_REQ_LEN   = w_blen_m1[7:0];
    end
    if ((r_state == c_st_data) && !w_fifo_empty) begin
      MEM_WDATA_VALID = 1'b1;
      MEM_WDATA       = r_mem[r_rd_ptr];
      MEM_WDATA_LAST  = w_last_beat;
    end
  end

  // Transfer counters
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_addr      <= '0;
      r_remaining <= 32'd0;
      r_total     <= 32'd0;
      r_accepted  <= 32'd0;
      r_beat      <= 9'd0;
    end else begin
      if ((r_state == c_st_idle) && start) begin
        r_addr      <= base_addr;
        r_remaining <= total_words;
        r_total     <= total_words;
        r_accepted  <= 32'd0;
      end
      if (w_push) begin
        r_accepted <= r_accepted + 32'd1;
      end
      if ((r_state == c_st_req) && MEM_REQ_READY) begin
        r_beat <= 9'd0;
      end
      if (w_pop) begin
        r_beat <= r_beat + 9'd1;
        if (w_last_beat) begin
          r_addr      <= r_addr + (C_ADDR_WIDTH'(w_blen) * c_word_bytes);
          r_remaining <= w_rem_after;
        end
      end
    end
  end

  // FIFO pointers and occupancy; push and pop together keep the count.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage needs no reset: the pointers define what is valid.
  always_ff @(posedge ACLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_s2mem_burst_writer.sv
`default_nettype none
// ============================================================================
// Module     : tb_s2mem_burst_writer
// Description: Directed self-checking bench for s2mem_burst_writer. A model
//              derives the expected burst list and beat sequence from the
//              transfer parameters and the words actually handed upstream.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_s2mem_burst_writer;

  logic        ACLK;
  logic        ARESET;
  logic        start;
  logic [31:0] base_addr;
  logic [31:0] total_words;
  logic        busy;
  logic        done;
  logic        ready;
  logic        data_valid;
  logic [31:0] data;
  logic        MEM_REQ_VALID;
  logic        MEM_REQ_READY;
  logic [31:0] MEM_REQ_ADDR;
  logic [7:0]  MEM_REQ_LEN;
  logic        MEM_WDATA_VALID;
  logic        MEM_WDATA_READY;
  logic [31:0] MEM_WDATA;
  logic        MEM_WDATA_LAST;

  s2mem_burst_writer dut (
    .ACLK            (ACLK),
    .ARESET          (ARESET),
    .start           (start),
    .base_addr       (base_addr),
    .total_words     (total_words),
    .busy            (busy),
    .done            (done),
    .ready           (ready),
    .data_valid      (data_valid),
    .data            (data),
    .MEM_REQ_VALID   (MEM_REQ_VALID),
    .MEM_REQ_READY   (MEM_REQ_READY),
    .MEM_REQ_ADDR    (MEM_REQ_ADDR),
    .MEM_REQ_LEN     (MEM_REQ_LEN),
    .MEM_WDATA_VALID (MEM_WDATA_VALID),
    .MEM_WDATA_READY (MEM_WDATA_READY),
    .MEM_WDATA       (MEM_WDATA),
    .MEM_WDATA_LAST  (MEM_WDATA_LAST)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  bit          active      = 1'b0;
  int          model_total = 0;
  int          model_acc   = 0;
  int          beat_cnt    = 0;
  int          done_cnt    = 0;
  int          d0          = 0;
  logic [31:0] acc_q[$];
  logic [39:0] exp_req_q[$];
  bit          exp_last_q[$];
  logic [31:0] log_addr[$];
  logic [7:0]  log_len[$];

  // Stimulus controls
  bit          src_en    = 1'b0;
  bit          src_gappy = 1'b0;
  bit          mem_gappy = 1'b0;
  bit          wr_hold   = 1'b0;
  int          src_idx   = 0;
  logic [31:0] src_base  = 32'd0;
  int          drv_cyc   = 0;

  // Handshake-hold tracking
  bit          prev_req_stall = 1'b0;
  bit          prev_w_stall   = 1'b0;
  logic [31:0] prev_addr;
  logic [7:0]  prev_len;
  logic [31:0] prev_wdata;
  logic        prev_last;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Upstream source and memory-side ready drivers
  initial begin
    data_valid      = 1'b0;
    data            = 32'd0;
    MEM_REQ_READY   = 1'b0;
    MEM_WDATA_READY = 1'b0;
    forever begin
      @(negedge ACLK);
      if (!ARESET && ready && data_valid) src_idx++;
      @(posedge ACLK);
      #1;
      drv_cyc++;
      data_valid      = src_en && !(src_gappy && (drv_cyc % 3 == 1));
      data            = src_base + 32'(src_idx);
      MEM_REQ_READY   = !mem_gappy || (drv_cyc % 2 == 0);
      MEM_WDATA_READY = !wr_hold && (!mem_gappy || (drv_cyc % 3 != 0));
    end
  end

  // Compare process
  initial begin
    logic [39:0] e;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        prev_req_stall = 1'b0;
        prev_w_stall   = 1'b0;
      end else begin
        if (prev_req_stall)
          chk("req_hold", 64'({MEM_REQ_VALID, MEM_REQ_LEN, MEM_REQ_ADDR}), 64'({1'b1, prev_len, prev_addr}));
        if (prev_w_stall)
          chk("wdata_hold", 64'({MEM_WDATA_VALID, MEM_WDATA_LAST, MEM_WDATA}), 64'({1'b1, prev_last, prev_wdata}));
        if (!active || model_acc >= model_total)
          chk("ready_limit", 64'(ready), 64'd0);
        if (!active)
          chk("idle_quiet", 64'({busy, MEM_REQ_VALID, MEM_WDATA_VALID}), 64'd0);
        if (ready && data_valid) begin
          acc_q.push_back(data);
          model_acc++;
        end
        if (MEM_REQ_VALID && MEM_REQ_READY) begin
          chk("req_expected", 64'(exp_req_q.size() > 0), 64'd1);
          if (exp_req_q.size() > 0) begin
            e = exp_req_q.pop_front();
            chk("req_addr", 64'(MEM_REQ_ADDR), 64'(e[31:0]));
            chk("req_len", 64'(MEM_REQ_LEN), 64'(e[39:32]));
            log_addr.push_back(MEM_REQ_ADDR);
            log_len.push_back(MEM_REQ_LEN);
          end
        end
        if (MEM_WDATA_VALID && MEM_WDATA_READY) begin
          chk("beat_expected", 64'(acc_q.size() > 0 && exp_last_q.size() > 0), 64'd1);
          if (acc_q.size() > 0 && exp_last_q.size() > 0) begin
            chk("beat_data", 64'(MEM_WDATA), 64'(acc_q.pop_front()));
            chk("beat_last", 64'(MEM_WDATA_LAST), 64'(exp_last_q.pop_front()));
          end
          beat_cnt++;
        end
        if (done) begin
          chk("done_active", 64'(active), 64'd1);
          chk("done_pending", 64'(acc_q.size() + exp_req_q.size() + exp_last_q.size()), 64'd0);
          chk("done_words", 64'(model_acc), 64'(model_total));
          chk("done_busy", 64'(busy), 64'd0);
          active = 1'b0;
          done_cnt++;
        end
        prev_req_stall = MEM_REQ_VALID && !MEM_REQ_READY;
        prev_addr      = MEM_REQ_ADDR;
        prev_len       = MEM_REQ_LEN;
        prev_w_stall   = MEM_WDATA_VALID && !MEM_WDATA_READY;
        prev_wdata     = MEM_WDATA;
        prev_last      = MEM_WDATA_LAST;
      end
    end
  end

  // Builds the expected bursts from the transfer parameters, then pulses start.
  task automatic run_start(input logic [31:0] base, input logic [31:0] total);
    logic [31:0] a;
    int          rem;
    int          b;
    a   = base;
    rem = int'(total);
    acc_q.delete();
    exp_req_q.delete();
    exp_last_q.delete();
    log_addr.delete();
    log_len.delete();
    while (rem > 0) begin
      b = (rem < 16) ? rem : 16;
      exp_req_q.push_back({8'(b - 1), a});
      for (int k = 0; k < b; k++) exp_last_q.push_back(k == b - 1);
      a   = a + 32'(b * 4);
      rem = rem - b;
    end
    model_total = int'(total);
    model_acc   = 0;
    beat_cnt    = 0;
    d0          = done_cnt;
    src_idx     = 0;
    src_base    = 32'hD000_0000 + base;
    active      = 1'b1;
    base_addr   = base;
    total_words = total;
    start       = 1'b1;
    @(posedge ACLK);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int exp_beats);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(posedge ACLK);
      n++;
    end
    chk({nm, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
    repeat (4) @(posedge ACLK);
    #1;
    chk({nm, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    chk({nm, "_beats"}, 64'(beat_cnt), 64'(exp_beats));
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_ctl"}, 64'({busy, done, ready, MEM_REQ_VALID, MEM_WDATA_VALID, MEM_WDATA_LAST}), 64'd0);
    chk({nm, "_addr"}, 64'(MEM_REQ_ADDR), 64'd0);
    chk({nm, "_len"}, 64'(MEM_REQ_LEN), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    ARESET      = 1'b1;
    start       = 1'b0;
    base_addr   = 32'd0;
    total_words = 32'd0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk_quiet("reset");
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    src_en = 1'b1;
    @(negedge ACLK);
    chk_quiet("after_reset");
    @(posedge ACLK);
    #1;

    // Two full bursts, continuous stream, memory always ready
    run_start(32'h0000_1000, 32'd32);
    wait_done("t1", 32);
    chk("t1_nreq", 64'(log_addr.size()), 64'd2);
    if (log_addr.size() == 2) begin
      chk("t1_addr0", 64'(log_addr[0]), 64'h1000);
      chk("t1_addr1", 64'(log_addr[1]), 64'h1040);
      chk("t1_len0", 64'(log_len[0]), 64'd15);
      chk("t1_len1", 64'(log_len[1]), 64'd15);
    end

    // Partial final burst, gappy stream and memory
    src_gappy = 1'b1;
    mem_gappy = 1'b1;
    run_start(32'h0000_1000, 32'd20);
    wait_done("t2", 20);
    chk("t2_nreq", 64'(log_addr.size()), 64'd2);
    if (log_addr.size() == 2) begin
      chk("t2_len0", 64'(log_len[0]), 64'd15);
      chk("t2_addr1", 64'(log_addr[1]), 64'h1040);
      chk("t2_len1", 64'(log_len[1]), 64'd3);
    end
    chk("t2_words", 64'(model_acc), 64'd20);
    src_gappy = 1'b0;
    mem_gappy = 1'b0;

    // Write data stalled: FIFO fills to its depth, then drains in order
    wr_hold = 1'b1;
    run_start(32'h0000_3000, 32'd48);
    repeat (40) @(posedge ACLK);
    @(negedge ACLK);
    #1;
    chk("t3_full_ready", 64'(ready), 64'd0);
    chk("t3_buffered", 64'(model_acc), 64'd32);
    chk("t3_no_beats", 64'(beat_cnt), 64'd0);
    @(posedge ACLK);
    #1;
    wr_hold = 1'b0;
    wait_done("t3", 48);
    chk("t3_nreq", 64'(log_addr.size()), 64'd3);

    // Zero-length transfer
    run_start(32'h0000_4000, 32'd0);
    @(negedge ACLK);
    #1;
    chk("t4_done_next", 64'(done), 64'd1);
    wait_done("t4", 0);
    chk("t4_nreq", 64'(log_addr.size()), 64'd0);
    chk("t4_words", 64'(model_acc), 64'd0);

    // Reset during the data phase, then a fresh transfer
    run_start(32'h0000_5000, 32'd16);
    n = 0;
    while (beat_cnt < 7 && n < 500) begin
      @(posedge ACLK);
      #1;
      n++;
    end
    chk("t5_beat7", 64'(beat_cnt), 64'd7);
    ARESET = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    chk_quiet("t5_rst");
    active = 1'b0;
    acc_q.delete();
    exp_req_q.delete();
    exp_last_q.delete();
    src_idx = 0;
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    run_start(32'h0000_6000, 32'd32);
    wait_done("t5b", 32);
    chk("t5b_nreq", 64'(log_addr.size()), 64'd2);
    if (log_addr.size() == 2) begin
      chk("t5b_addr0", 64'(log_addr[0]), 64'h6000);
      chk("t5b_addr1", 64'(log_addr[1]), 64'h6040);
    end

    // Address wrap, start pulse while busy is ignored
    run_start(32'hFFFF_FFC0, 32'd32);
    repeat (5) @(posedge ACLK);
    #1;
    base_addr   = 32'h0000_5000;
    total_words = 32'd5;
    start       = 1'b1;
    @(posedge ACLK);
    #1;
    start = 1'b0;
    chk("t6_busy", 64'(busy), 64'd1);
    wait_done("t6", 32);
    chk("t6_nreq", 64'(log_addr.size()), 64'd2);
    if (log_addr.size() == 2) begin
      chk("t6_addr0", 64'(log_addr[0]), 64'hFFFF_FFC0);
      chk("t6_addr1", 64'(log_addr[1]), 64'h0000_0000);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
